alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result entries held; power of two, >= 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream ALU result valid this cycle.
REQ-005 SHALL have port in_ready  output  1  buffer can accept a result.
REQ-006 SHALL have port in_result  input  4  ALU_Out value from the 4-bit ALU.
REQ-007 SHALL have port in_carry  input  1  CarryOut value from the 4-bit ALU.
REQ-008 SHALL have port in_op  input  4  ALU_Sel opcode that produced in_result.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  downstream consumes head entry.
REQ-011 SHALL have port out_result  output  4  head entry result.
REQ-012 SHALL have port out_carry  output  1  head entry carry.
REQ-013 SHALL have port out_op  output  4  head entry opcode.
REQ-014 SHALL have port out_zero  output  1  head result == 0 (flag feature).
REQ-015 SHALL have port out_neg  output  1  head result bit 3 (flag feature).
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL accept (push) an entry on a rising edge where in_valid && in_ready.
REQ-018 SHALL release (pop) the head entry on a rising edge where out_valid && out_ready.
REQ-019 SHALL drive in_ready = (count < DEPTH); no same-cycle pass-through when full.
REQ-020 SHALL drive out_valid = (count != 0); no bypass, so push-to-out_valid latency is exactly 1 cycle.
REQ-021 SHALL store carry = in_carry only when in_op == ADD (4'b0000), else store 0.
REQ-022 SHALL present out_result/out_carry/out_op from the head entry, stable while out_valid && !out_ready.
REQ-023 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged and preserve FIFO order.
REQ-024 SHALL, when full, ignore in_valid; when empty, never pop regardless of out_ready.
REQ-025 SHALL wrap read/write pointers modulo DEPTH with no lost or duplicated entries.
REQ-026 SHALL drive out_result/out_carry/out_op/out_zero/out_neg to 0 when out_valid is 0.

Reset
REQ-027 SHALL, on rst_n low, immediately clear pointers and count; out_valid = 0, in_ready = 1, all data outputs 0.
REQ-028 SHALL discard all held entries when reset asserts mid-operation; entry storage need not be cleared.
REQ-029 SHALL resume accepting pushes on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with ALU_RB_FLAGS_EN defined, drive out_zero = (out_result == 0) && out_valid and out_neg = out_result[3] && out_valid, computed at push and stored per entry.
REQ-031 SHALL, without ALU_RB_FLAGS_EN, keep ports out_zero/out_neg present and tied to 0, with no flag storage.

Structure
REQ-032 SHALL take alu_op_t (16 opcodes, ADD = 4'b0000) and the entry struct alu_rb_entry_t {result, carry, op, zero, neg} from shared package alu_pkg.
REQ-033 SHALL implement storage and pointers in a single sub-module alu_rb_fifo; the top handles carry masking and flags.

Verification
REQ-034 SHALL cover: push result 4'hA, carry 1, op ADD -> next cycle out_valid = 1, out_result = 4'hA, out_carry = 1, count = 1.
REQ-035 SHALL cover: push carry 1 with op 4'b1000 (AND) -> out_carry = 0.
REQ-036 SHALL cover: out_ready = 0, push 4 results 1,2,3,4 -> count = 4, in_ready = 0; a fifth in_valid is dropped; drain yields 1,2,3,4.
REQ-037 SHALL cover: count = 2, push and pop on the same edge -> count stays 2, order preserved across pointer wrap.
REQ-038 SHALL cover: ALU_RB_FLAGS_EN defined, push 4'h0 then 4'h9 -> out_zero = 1,0 and out_neg = 0,1.
REQ-039 SHALL cover: 3 entries held, rst_n pulsed low mid-cycle -> count = 0, out_valid = 0, in_ready = 1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU result buffer: opcode enum and per-entry record.
// Entry layout is result, carry, op, zero, neg (MSB first).
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROL  = 4'h6,
        OP_ROR  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_t;

    typedef struct packed {
        logic [3:0] result;
        logic       carry;
        alu_op_t    op;
        logic       zero;
        logic       neg;
    } alu_rb_entry_t;

    localparam int BASE_W = 9;
    localparam int FULL_W = $bits(alu_rb_entry_t);

endpackage

// File: rtl/alu_rb_fifo.sv
// Circular storage, pointers and occupancy for the ALU result buffer.
// Push is blocked when full and pop when empty; pointers wrap modulo DEPTH.
module alu_rb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Buffers 4-bit ALU results with carry masking and optional zero/neg flags.
// Flags are stored per entry only when ALU_RB_FLAGS_EN is defined.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_result,
    input  logic                   in_carry,
    input  logic [3:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_result,
    output logic                   out_carry,
    output logic [3:0]             out_op,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic [$clog2(DEPTH):0] count
);

`ifdef ALU_RB_FLAGS_EN
    localparam int W = FULL_W;
`else
    localparam int W = BASE_W;
`endif

    logic [W-1:0]  wr_data;
    logic [W-1:0]  rd_data;
    logic          full;
    logic          empty;
    logic          carry_m;
    alu_rb_entry_t head;

    // Carry is only meaningful for ADD.
    assign carry_m = (alu_op_t'(in_op) == OP_ADD) & in_carry;

`ifdef ALU_RB_FLAGS_EN
    assign wr_data = {in_result, carry_m, in_op,
                      (in_result == 4'h0), in_result[3]};
    assign head    = alu_rb_entry_t'(rd_data);
`else
    assign wr_data = {in_result, carry_m, in_op};
    always_comb begin
        head        = '0;
        head.result = rd_data[8:5];
        head.carry  = rd_data[4];
        head.op     = alu_op_t'(rd_data[3:0]);
    end
`endif

    alu_rb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .pop     (out_ready),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign in_ready   = ~full;
    assign out_valid  = ~empty;
    assign out_result = out_valid ? head.result : 4'h0;
    assign out_carry  = out_valid & head.carry;
    assign out_op     = out_valid ? head.op : 4'h0;
    assign out_zero   = out_valid & head.zero;
    assign out_neg    = out_valid & head.neg;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed plus random checks of alu_result_buffer against a queue model.
module tb_alu_result_buffer;

    localparam int DEPTH = 4;
`ifdef ALU_RB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_result = '0;
    logic       in_carry = 1'b0;
    logic [3:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_carry;
    logic [3:0] out_op;
    logic       out_zero;
    logic       out_neg;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [3:0] res;
        logic       c;
        logic [3:0] op;
    } ent_t;

    ent_t q[$];
    int errors = 0;
    int checks = 0;

    alu_result_buffer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_carry   (in_carry),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_op     (out_op),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(string tag);
        int         n = q.size();
        logic [3:0] er = 4'h0;
        logic       ec = 1'b0;
        logic [3:0] eo = 4'h0;
        logic       ez = 1'b0;
        logic       en = 1'b0;
        if (n > 0) begin
            er = q[0].res;
            ec = q[0].c;
            eo = q[0].op;
            ez = FLAGS && (er == 4'h0);
            en = FLAGS && er[3];
        end
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(n < DEPTH));
        chk({tag, ".out_result"}, 32'(out_result), 32'(er));
        chk({tag, ".out_carry"}, 32'(out_carry), 32'(ec));
        chk({tag, ".out_op"}, 32'(out_op), 32'(eo));
        chk({tag, ".out_zero"}, 32'(out_zero), 32'(ez));
        chk({tag, ".out_neg"}, 32'(out_neg), 32'(en));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic cycle(string tag, bit v, logic [3:0] r, bit c,
                         logic [3:0] op, bit ordy);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        in_valid  = v;
        in_result = r;
        in_carry  = c;
        in_op     = op;
        out_ready = ordy;
        do_push   = v && (q.size() < DEPTH);
        do_pop    = ordy && (q.size() != 0);
        e.res = r;
        e.c   = (op == 4'h0) ? c : 1'b0;
        e.op  = op;
        @(posedge clk);
        if (do_pop)
            void'(q.pop_front());
        if (do_push)
            q.push_back(e);
        #1;
        check_state(tag);
    endtask

    task automatic drain(string tag);
        for (int i = 0; i < DEPTH + 1; i++)
            cycle(tag, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        #1;
        check_state("reset");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        cycle("push_add", 1'b1, 4'hA, 1'b1, 4'h0, 1'b0);
        drain("drain_add");

        cycle("push_and", 1'b1, 4'h5, 1'b1, 4'h8, 1'b0);
        chk("and_carry_masked", 32'(out_carry), 32'd0);
        drain("drain_and");

        for (int i = 1; i <= 4; i++)
            cycle("fill", 1'b1, 4'(i), 1'b1, 4'h0, 1'b0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle("fifth_dropped", 1'b1, 4'hF, 1'b0, 4'h1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", 32'(out_result), 32'(i));
            cycle("drain_full", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        end

        cycle("pp_pre1", 1'b1, 4'h3, 1'b0, 4'h2, 1'b0);
        cycle("pp_pre2", 1'b1, 4'h7, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            cycle("push_pop", 1'b1, 4'(8 + i), 1'b1, 4'(i), 1'b1);
        chk("pp_count", 32'(count), 32'd2);
        drain("drain_pp");

        cycle("flag_zero", 1'b1, 4'h0, 1'b0, 4'h1, 1'b0);
        cycle("flag_neg", 1'b1, 4'h9, 1'b0, 4'h1, 1'b0);
        chk("zero_first", 32'(out_zero), 32'(FLAGS));
        cycle("flag_pop", 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        chk("neg_second", 32'(out_neg), 32'(FLAGS));
        drain("drain_flags");

        for (int i = 0; i < 3; i++)
            cycle("pre_rst", 1'b1, 4'(i + 4), 1'b0, 4'h3, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check_state("async_rst");
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst_idle");
        cycle("post_rst_push", 1'b1, 4'hC, 1'b1, 4'h0, 1'b0);
        drain("drain_rst");

        for (int i = 0; i < 400; i++)
            cycle("random", 1'($urandom), 4'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom),
                  1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
